// File: rtl/rf_if_arbiter.sv
// rf_if_arbiter: shares one RF transceiver register interface between
// NUM_REQ requesters. Round-robin grant, one transaction in flight, the
// interface's ready is ignored for READY_GUARD cycles after the strobe, and a
// transaction that never sees ready again is aborted with an error response.
module rf_if_arbiter #(
   parameter int NUM_REQ     = 3,
   parameter int READY_GUARD = 3,
   parameter int TIMEOUT     = 4095
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [2*NUM_REQ-1:0]   req_inst,
   input  logic [10*NUM_REQ-1:0]  req_addr,
   input  logic [8*NUM_REQ-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]     req_ack,
   output logic [NUM_REQ-1:0]     rsp_valid,
   output logic [7:0]             rsp_rdata,
   output logic                   rsp_err,
   input  logic                   rf_ready,
   input  logic [7:0]             rf_rdata,
   output logic [1:0]             rf_inst,
   output logic [9:0]             rf_addr,
   output logic [7:0]             rf_data,
   output logic                   rf_cs,
   output logic                   busy,
   output logic [1:0]             grant_id
);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      GUARD,
      WAIT_RDY,
      RESP
   } state_t;

   state_t      state;
   logic [1:0]  ptr;
   logic [11:0] cnt;

   logic        found;
   logic [1:0]  pick;
   logic [2:0]  cand;
   logic [1:0]  sel_inst;
   logic [9:0]  sel_addr;
   logic [7:0]  sel_wdata;

   // Short ops only reach the lower 64 registers; the upper address bits are zeroed.
   function automatic logic [9:0] port_addr(input logic [1:0] inst, input logic [9:0] addr);
      return inst[1] ? addr : {4'b0000, addr[5:0]};
   endfunction

   function automatic logic [NUM_REQ-1:0] onehot(input logic [1:0] id);
      logic [NUM_REQ-1:0] v;
      for (int j = 0; j < NUM_REQ; j++) v[j] = (id == 2'(j));
      return v;
   endfunction

   // Round-robin search from ptr upward (wrapping), then mux out the winner's fields.
   always_comb begin
      found     = 1'b0;
      pick      = ptr;
      cand      = '0;
      sel_inst  = '0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = 3'(ptr) + 3'(k);
         if (cand >= 3'(NUM_REQ)) cand = cand - 3'(NUM_REQ);
         for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req_valid[j] && cand == 3'(j)) begin
               found = 1'b1;
               pick  = 2'(j);
            end
         end
      end
      for (int j = 0; j < NUM_REQ; j++) begin
         if (pick == 2'(j)) begin
            sel_inst  = req_inst[2*j +: 2];
            sel_addr  = req_addr[10*j +: 10];
            sel_wdata = req_wdata[8*j +: 8];
         end
      end
   end

   // Transaction FSM; every output is a register written here. The rf_* output
   // registers double as the latched request, so later req_* changes are ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         cnt       <= '0;
         req_ack   <= '0;
         rsp_valid <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         rf_inst   <= '0;
         rf_addr   <= '0;
         rf_data   <= '0;
         rf_cs     <= 1'b0;
         busy      <= 1'b0;
         grant_id  <= '0;
      end else begin
         req_ack   <= '0;
         rsp_valid <= '0;
         rf_cs     <= 1'b0;
         case (state)
            IDLE: begin
               if (rf_ready && found) begin
                  rf_inst  <= sel_inst;
                  rf_addr  <= port_addr(sel_inst, sel_addr);
                  rf_data  <= sel_wdata;
                  grant_id <= pick;
                  ptr      <= (pick == 2'(NUM_REQ - 1)) ? 2'd0 : pick + 2'd1;
                  req_ack  <= onehot(pick);
                  busy     <= 1'b1;
                  state    <= SETUP;
               end
            end
            SETUP: begin
               rf_cs <= 1'b1;
               state <= STROBE;
            end
            STROBE: begin
               cnt   <= '0;
               state <= (READY_GUARD == 0) ? WAIT_RDY : GUARD;
            end
            GUARD: begin
               if (cnt == 12'(READY_GUARD - 1)) begin
                  cnt   <= '0;
                  state <= WAIT_RDY;
               end else begin
                  cnt <= cnt + 12'd1;
               end
            end
            WAIT_RDY: begin
               if (rf_ready) begin
                  rsp_rdata <= rf_inst[0] ? 8'h00 : rf_rdata;
                  rsp_err   <= 1'b0;
                  rsp_valid <= onehot(grant_id);
                  state     <= RESP;
               end else if (cnt == 12'(TIMEOUT - 1)) begin
                  rsp_rdata <= 8'h00;
                  rsp_err   <= 1'b1;
                  rsp_valid <= onehot(grant_id);
                  state     <= RESP;
               end else begin
                  cnt <= cnt + 12'd1;
               end
            end
            RESP: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rf_if_arbiter.sv
// Bench for rf_if_arbiter: directed transactions, a small RF interface model,
// and a scoreboard monitor that checks every strobe and every response.
module tb_rf_if_arbiter;
   localparam int NUM_REQ     = 3;
   localparam int READY_GUARD = 3;
   localparam int TIMEOUT     = 4095;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NUM_REQ-1:0]    req_valid;
   logic [2*NUM_REQ-1:0]  req_inst;
   logic [10*NUM_REQ-1:0] req_addr;
   logic [8*NUM_REQ-1:0]  req_wdata;
   logic [NUM_REQ-1:0]    req_ack;
   logic [NUM_REQ-1:0]    rsp_valid;
   logic [7:0]            rsp_rdata;
   logic                  rsp_err;
   logic                  rf_ready;
   logic [7:0]            rf_rdata;
   logic [1:0]            rf_inst;
   logic [9:0]            rf_addr;
   logic [7:0]            rf_data;
   logic                  rf_cs;
   logic                  busy;
   logic [1:0]            grant_id;

   rf_if_arbiter #(.NUM_REQ(NUM_REQ), .READY_GUARD(READY_GUARD), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_inst(req_inst), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .rf_ready(rf_ready), .rf_rdata(rf_rdata), .rf_inst(rf_inst), .rf_addr(rf_addr),
      .rf_data(rf_data), .rf_cs(rf_cs), .busy(busy), .grant_id(grant_id)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   logic [19:0] exp_cs[$];   // {inst, addr, data} expected at each rf_cs
   logic [10:0] exp_rsp[$];  // {id, err, rdata} expected at each rsp_valid

   // RF model behaviour: 0 = ready stays high, 1 = low for rf_delay cycles after cs,
   // 2 = low forever after cs. rf_block forces ready low.
   int mode = 0;
   int rf_delay = 0;
   bit rf_block = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_req(input int i, input logic [1:0] inst, input logic [9:0] addr, input logic [7:0] wdata);
      req_inst[2*i +: 2]   = inst;
      req_addr[10*i +: 10] = addr;
      req_wdata[8*i +: 8]  = wdata;
   endtask

   // Raise one request in an IDLE cycle; report the cycle of req_ack and of rsp_valid.
   task automatic measure(input int i, input logic [1:0] inst, input logic [9:0] addr,
                          input logic [7:0] wdata, input int limit,
                          output int ack_at, output int rsp_at);
      int lat;
      lat    = 0;
      ack_at = -1;
      set_req(i, inst, addr, wdata);
      req_valid[i] = 1'b1;
      do begin
         @(negedge clk);
         lat++;
         if (req_ack[i]) begin
            req_valid[i] = 1'b0;
            if (ack_at < 0) ack_at = lat;
         end
      end while (!rsp_valid[i] && lat < limit);
      req_valid[i] = 1'b0;
      rsp_at = lat;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < 6000);
      check("idle_reached", 32'(busy), 32'd0);
      @(negedge clk);
   endtask

   // RF interface model, updated just after each rising edge.
   initial begin
      int  low;
      bit  hold;
      low = 0;
      hold = 1'b0;
      rf_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         if (mode != 2) hold = 1'b0;
         if (rf_cs === 1'b1) begin
            if (mode == 2) hold = 1'b1;
            else if (mode == 1) low = rf_delay;
         end else if (low > 0) begin
            low--;
         end
         rf_ready = !(rf_block || hold || low > 0);
      end
   end

   // Scoreboard monitor: pops an expectation for every strobe and every response.
   initial begin
      logic [19:0] ec;
      logic [10:0] er;
      logic [1:0]  id;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (rf_cs === 1'b1) begin
               if (exp_cs.size() == 0) check("cs_unexpected", 32'd1, 32'd0);
               else begin
                  ec = exp_cs.pop_front();
                  check("cs_fields", 32'({rf_inst, rf_addr, rf_data}), 32'(ec));
               end
            end
            if (req_ack != '0) check("ack_onehot", 32'($countones(req_ack)), 32'd1);
            if (rsp_valid != '0) begin
               check("rsp_onehot", 32'($countones(rsp_valid)), 32'd1);
               id = '0;
               for (int j = 0; j < NUM_REQ; j++) if (rsp_valid[j]) id = 2'(j);
               if (exp_rsp.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
               else begin
                  er = exp_rsp.pop_front();
                  check("rsp_fields", 32'({id, rsp_err, rsp_rdata}), 32'(er));
               end
            end
         end
      end
   end

   // Overall time bound.
   initial begin
      #200000;
      miscompares++;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "watchdog expired");
   end

   // Directed stimulus.
   initial begin
      int ack_at, rsp_at, got, cs_local, bad, first_ack;
      req_valid = '0;
      req_inst  = '0;
      req_addr  = '0;
      req_wdata = '0;
      rf_rdata  = 8'h00;
      rst       = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_ctrl", 32'({req_ack, rsp_valid, rf_cs, busy, grant_id, rsp_err}), 32'd0);
      check("reset_data", 32'({rsp_rdata, rf_inst, rf_addr, rf_data}), 32'd0);

      // Short read from req0; upper address bits dropped.
      mode = 1; rf_delay = 5; rf_rdata = 8'h5A;
      exp_cs.push_back({2'b00, 10'h031, 8'h77});
      exp_rsp.push_back({2'd0, 1'b0, 8'h5A});
      measure(0, 2'b00, 10'h231, 8'h77, 100, ack_at, rsp_at);
      check("rd_ack_latency", 32'(ack_at), 32'd1);
      check("rd_rsp_latency", 32'(rsp_at), 32'd8);
      wait_idle();

      // Long write from req1 with ready always high: response at T+7.
      mode = 0;
      exp_cs.push_back({2'b11, 10'h200, 8'hC3});
      exp_rsp.push_back({2'd1, 1'b0, 8'h00});
      measure(1, 2'b11, 10'h200, 8'hC3, 100, ack_at, rsp_at);
      check("wr_ack_latency", 32'(ack_at), 32'd1);
      check("wr_rsp_latency", 32'(rsp_at), 32'(4 + READY_GUARD));
      wait_idle();

      // Timeout on req2: ready never returns after the strobe.
      mode = 2; rf_rdata = 8'hEE;
      exp_cs.push_back({2'b10, 10'h3FF, 8'h11});
      exp_rsp.push_back({2'd2, 1'b1, 8'h00});
      measure(2, 2'b10, 10'h3FF, 8'h11, 6000, ack_at, rsp_at);
      check("to_rsp_latency", 32'(rsp_at), 32'(3 + READY_GUARD + TIMEOUT));
      mode = 0;
      @(negedge clk);
      check("to_back_idle", 32'(busy), 32'd0);
      wait_idle();

      // Round robin with all three requests held.
      rf_rdata = 8'h3C;
      set_req(0, 2'b00, 10'h3C5, 8'h01);
      set_req(1, 2'b10, 10'h155, 8'h02);
      set_req(2, 2'b01, 10'h2AA, 8'h03);
      for (int r = 0; r < 2; r++) begin
         exp_cs.push_back({2'b00, 10'h005, 8'h01});
         exp_rsp.push_back({2'd0, 1'b0, 8'h3C});
         exp_cs.push_back({2'b10, 10'h155, 8'h02});
         exp_rsp.push_back({2'd1, 1'b0, 8'h3C});
         exp_cs.push_back({2'b01, 10'h02A, 8'h03});
         exp_rsp.push_back({2'd2, 1'b0, 8'h00});
      end
      got = 0; cs_local = 0;
      req_valid = 3'b111;
      for (int n = 0; n < 200 && got < 6; n++) begin
         @(negedge clk);
         if (rf_cs) cs_local++;
         if (rsp_valid != '0) got++;
      end
      req_valid = '0;
      check("rr_rsp_count", 32'(got), 32'd6);
      check("rr_cs_count", 32'(cs_local), 32'd6);
      wait_idle();

      // Blocked start: no grant while rf_ready is low.
      rf_block = 1'b1;
      repeat (2) @(negedge clk);
      set_req(0, 2'b01, 10'h0F0, 8'h99);
      exp_cs.push_back({2'b01, 10'h030, 8'h99});
      exp_rsp.push_back({2'd0, 1'b0, 8'h00});
      req_valid[0] = 1'b1;
      bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (req_ack != '0 || busy) bad++;
      end
      check("blocked_no_grant", 32'(bad), 32'd0);
      rf_block = 1'b0;
      @(negedge clk);
      check("ready_rise_no_ack", 32'({rf_ready, req_ack}), 32'({1'b1, 3'b000}));
      @(negedge clk);
      check("ack_after_ready", 32'(req_ack), 32'(3'b001));
      req_valid[0] = 1'b0;
      wait_idle();

      // Reset during GUARD: outputs clear at once, no response follows.
      set_req(0, 2'b10, 10'h2F0, 8'h55);
      exp_cs.push_back({2'b10, 10'h2F0, 8'h55});
      req_valid[0] = 1'b1;
      @(negedge clk);
      check("mid_ack", 32'(req_ack), 32'(3'b001));
      req_valid[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_reset_ctrl", 32'({req_ack, rsp_valid, rf_cs, busy, grant_id, rsp_err}), 32'd0);
      check("mid_reset_data", 32'({rsp_rdata, rf_inst, rf_addr, rf_data}), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Pointer restarts at 0: req0 beats req2 even though req0 was granted last.
      rf_rdata = 8'h81;
      set_req(0, 2'b00, 10'h011, 8'h00);
      set_req(2, 2'b01, 10'h122, 8'h44);
      exp_cs.push_back({2'b00, 10'h011, 8'h00});
      exp_rsp.push_back({2'd0, 1'b0, 8'h81});
      exp_cs.push_back({2'b01, 10'h022, 8'h44});
      exp_rsp.push_back({2'd2, 1'b0, 8'h00});
      first_ack = 0;
      req_valid = 3'b101;
      for (int n = 0; n < 100 && req_valid != '0; n++) begin
         @(negedge clk);
         if (req_ack != '0 && first_ack == 0) first_ack = int'(req_ack);
         if (req_ack[0]) req_valid[0] = 1'b0;
         if (req_ack[2]) req_valid[2] = 1'b0;
      end
      req_valid = '0;
      check("post_reset_first", 32'(first_ack), 32'd1);
      wait_idle();

      exp_cs.push_back({2'b10, 10'h1AB, 8'h00});
      exp_rsp.push_back({2'd1, 1'b0, 8'h81});
      measure(1, 2'b10, 10'h1AB, 8'h00, 100, ack_at, rsp_at);
      check("req1_ack_latency", 32'(ack_at), 32'd1);
      wait_idle();

      repeat (3) @(negedge clk);
      check("cs_queue_empty", 32'(exp_cs.size()), 32'd0);
      check("rsp_queue_empty", 32'(exp_rsp.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
